hilo_div_ctrl: RTL
==================

// Module: hilo_div_ctrl
// PURPOSE
//  Sequences the iterative radix-4 divider (17-cycle, level-held 'div' start) for the CPU's DIV/DIVU.
//  Owns the HI/LO registers and accepts divide requests via valid/ready.
//  Holds operands stable, drops 'div' on completion or flush, and commits quotient->LO, remainder->HI.
//  Also serves MTHI/MTLO writes. Sits between the EX stage and the divider instance in the parent.
// PARAMETERS
//  DIV_LAT  17  cycles from first dv_div-high edge to dv_complete; sets the watchdog limit
// PORTS
//  div_clk      in   1   clock; all state on rising edge
//  resetn       in   1   asynchronous, active-low reset
//  req_valid    in   1   divide request
//  req_ready    out  1   combinational: state==IDLE && !flush
//  req_signed   in   1   1=DIV, 0=DIVU
//  req_x        in   32  dividend
//  req_y        in   32  divisor
//  flush        in   1   pipeline flush; cancels an in-flight divide
//  wr_hi        in   1   MTHI strobe
//  wr_lo        in   1   MTLO strobe
//  wr_data      in   32  MTHI/MTLO data
//  hi           out  32  HI register
//  lo           out  32  LO register
//  busy         out  1   state==RUN; EX stalls MFHI/MFLO/MT*/DIV while high
//  done         out  1   one-cycle pulse in the cycle hi/lo first show a committed result
//  err          out  1   sticky protocol/watchdog error, cleared only by reset
//  dv_div       out  1   to divider 'div' (registered)
//  dv_signed    out  1   to divider 'div_signed' (registered)
//  dv_x         out  32  to divider 'x' (registered operand)
//  dv_y         out  32  to divider 'y' (registered operand)
//  dv_s         in   32  divider quotient
//  dv_r         in   32  divider remainder
//  dv_complete  in   1   divider completion (high for one cycle)
// BEHAVIOUR
//  Reset: state=IDLE; hi, lo, dv_x, dv_y = 0; dv_div, dv_signed, done, err, wdog = 0.
//  FSM IDLE->RUN: on req_valid && req_ready (edge E0).
//   - Latch dv_x/dv_y/dv_signed; set dv_div=1; wdog=0.
//   - Divider samples operands at E1.
//  RUN, dv_complete && !flush (edge E18 = accept+18):
//   - lo<=dv_s, hi<=dv_r; dv_div<=0; done<=1; ->IDLE.
//   - done and new hi/lo are visible in the same cycle.
//  RUN, flush (any cycle, including one with dv_complete): flush wins.
//   - dv_div<=0; ->IDLE; hi/lo untouched; no done.
//   - dv_div low for >=1 cycle guarantees the divider counter returns to 0.
//  Watchdog: wdog counts RUN cycles.
//   - If wdog reaches DIV_LAT+2 without dv_complete: err<=1; dv_div<=0; ->IDLE; no commit.
//  Back-to-back: a request is accepted in the cycle done is high (state IDLE).
//   - dv_div therefore sees one low cycle between jobs.
//  dv_x/dv_y/dv_signed change only on accept; they are stable throughout RUN.
//  wr_hi/wr_lo in IDLE: write wr_data at the edge.
//   - Both together write both registers.
//   - If coincident with acceptance, the write applies and the divide still launches.
//  wr_hi/wr_lo while busy: ignored; err<=1 (EX must stall).
//  req_valid while busy: not accepted; no error.
//  Divide by zero: run normally; commit whatever the divider returns (architecturally UNPREDICTABLE).
//  Reset mid-operation: immediate return to reset values; dv_div low resets the divider.
// STRUCTURE
//  Shared package div_pkg: state encoding (IDLE=1'b0, RUN=1'b1), DIV_LAT default, watchdog width
//   $clog2(DIV_LAT+3).
//  No sub-module: single FSM plus operand/HI/LO registers. The divider is instantiated by the
//   parent and wired to dv_*.
// TESTING (bench uses the real divider)
//  1) DIVU 100/7 accepted at E0 -> dv_div=1 E0..E18; done at E18; lo=14, hi=2.
//  2) DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
//  3) Preset hi=0xAAAA, lo=0x5555 via MT*. DIV 50/5, flush at accept+5 -> no done; hi/lo unchanged;
//     dv_div low next cycle. DIVU 16/3 then gives lo=5, hi=1 at its +18.
//  4) Flush coincident with dv_complete -> no commit, no done.
//     New request in the done cycle -> second result correct.
//  5) Stub divider never completes -> err=1 and dv_div=0 at accept+DIV_LAT+2; state IDLE.
//     wr_lo while busy -> err=1, lo unchanged.
//  6) resetn low at accept+9 -> all outputs 0 immediately.
//     After release, DIVU 9/4 -> lo=2, hi=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the HI/LO divide controller: FSM encoding and divider timing defaults.
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DIV_LAT_DEF = 17;

  // Watchdog must be able to hold DIV_LAT+2.
  function automatic int wdog_width(input int lat);
    return $clog2(lat + 3);
  endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// Sequences an external iterative divider for DIV/DIVU and owns HI/LO (also written by MTHI/MTLO).
// Launch registers operands and holds 'div' high until completion, flush or watchdog timeout.
module hilo_div_ctrl
  import div_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        div_clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic        flush,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        dv_div,
  output logic        dv_signed,
  output logic [31:0] dv_x,
  output logic [31:0] dv_y,
  input  logic [31:0] dv_s,
  input  logic [31:0] dv_r,
  input  logic        dv_complete
);

  localparam int WW = wdog_width(DIV_LAT);
  localparam logic [WW-1:0] WDOG_LIM = WW'(DIV_LAT + 2);

  state_e        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   x_q, x_d, y_q, y_d;
  logic          sgn_q, sgn_d;
  logic          div_q, div_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          accept;

  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    x_d     = x_q;
    y_d     = y_q;
    sgn_d   = sgn_q;
    div_d   = div_q;
    done_d  = 1'b0;
    err_d   = err_q;
    wdog_d  = wdog_q;
    case (state_q)
      IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (accept) begin
          state_d = RUN;
          x_d     = req_x;
          y_d     = req_y;
          sgn_d   = req_signed;
          div_d   = 1'b1;
          wdog_d  = '0;
        end
      end
      RUN: begin
        // MT* while busy means EX failed to stall; drop the write and flag it.
        if (wr_hi || wr_lo) err_d = 1'b1;
        wdog_d = wdog_q + 1'b1;
        if (flush) begin
          div_d   = 1'b0;
          state_d = IDLE;
        end else if (dv_complete) begin
          lo_d    = dv_s;
          hi_d    = dv_r;
          div_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (wdog_d == WDOG_LIM) begin
          err_d   = 1'b1;
          div_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sgn_q   <= 1'b0;
      div_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      div_q   <= div_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign err       = err_q;
  assign dv_div    = div_q;
  assign dv_signed = sgn_q;
  assign dv_x      = x_q;
  assign dv_y      = y_q;

endmodule
